// File: rtl/stack_op_sequencer.sv
// Command sequencer that owns the hardware stack's PUSH/POP/TOS strobes.
// Tracks stack depth locally so it can reject underflow/overflow before touching the stack.

module stack_op_sequencer #(
   parameter int W     = 8,
   parameter int DEPTH = 32,
   localparam int DW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [W-1:0]  cmd_imm,
   output logic          done,
   output logic          err,
   output logic [W-1:0]  result,
   output logic [DW-1:0] depth,
   output logic          stk_push,
   output logic          stk_pop,
   output logic          stk_tos,
   output logic [W-1:0]  stk_din,
   input  logic [W-1:0]  stk_dout
);

   // state  | meaning
   // IDLE   | waiting for a command, cmd_ready high
   // POP1   | first pop strobe (top of stack)
   // POP2   | second pop strobe, top value captured into operand b
   // TOS1   | read top of stack without removing it (DUP)
   // CAP    | capture popped value into result (POP)
   // WR     | push strobe with computed value on stk_din
   // DONE   | one-cycle done/err pulse
   typedef enum logic [2:0] {
      S_IDLE, S_POP1, S_POP2, S_TOS1, S_CAP, S_WR, S_DONE
   } state_t;

   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_POP  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_NOT  = 3'b110;
   localparam logic [2:0] OP_DUP  = 3'b111;

   localparam logic [DW-1:0] FULL = DW'(DEPTH);
   localparam logic [DW-1:0] ONE  = DW'(1);
   localparam logic [DW-1:0] TWO  = DW'(2);

   state_t        state, state_nxt;
   logic [2:0]    op_q;
   logic [W-1:0]  imm_q;
   logic [W-1:0]  b_q;
   logic          err_q;
   logic [W-1:0]  result_q;
   logic [DW-1:0] depth_q;

   logic          accept;
   logic          legal;
   logic [W-1:0]  wr_value;

   assign accept = (state == S_IDLE) && cmd_valid;

   always_comb begin
      legal = 1'b0;
      case (cmd_op)
         OP_PUSH:                        legal = (depth_q < FULL);
         OP_POP, OP_NOT:                 legal = (depth_q >= ONE);
         OP_DUP:                         legal = (depth_q >= ONE) && (depth_q < FULL);
         OP_ADD, OP_SUB, OP_AND, OP_OR:  legal = (depth_q >= TWO);
         default:                        legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (!legal) begin
                  state_nxt = S_DONE;
               end else begin
                  case (cmd_op)
                     OP_PUSH: state_nxt = S_WR;
                     OP_DUP:  state_nxt = S_TOS1;
                     default: state_nxt = S_POP1;
                  endcase
               end
            end
         end
         S_POP1: begin
            case (op_q)
               OP_POP:  state_nxt = S_CAP;
               OP_NOT:  state_nxt = S_WR;
               default: state_nxt = S_POP2;
            endcase
         end
         S_POP2:  state_nxt = S_WR;
         S_TOS1:  state_nxt = S_WR;
         S_CAP:   state_nxt = S_DONE;
         S_WR:    state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // stk_dout is the stack's registered output, so wr_value is stable through WR
   always_comb begin
      wr_value = '0;
      case (op_q)
         OP_PUSH: wr_value = imm_q;
         OP_ADD:  wr_value = stk_dout + b_q;
         OP_SUB:  wr_value = stk_dout - b_q;
         OP_AND:  wr_value = stk_dout & b_q;
         OP_OR:   wr_value = stk_dout | b_q;
         OP_NOT:  wr_value = ~stk_dout;
         OP_DUP:  wr_value = stk_dout;
         default: wr_value = '0;
      endcase
   end

   assign stk_push  = (state == S_WR);
   assign stk_pop   = (state == S_POP1) || (state == S_POP2);
   assign stk_tos   = (state == S_TOS1);
   assign stk_din   = (state == S_WR) ? wr_value : '0;
   assign cmd_ready = (state == S_IDLE);
   assign done      = (state == S_DONE);
   assign err       = (state == S_DONE) && err_q;
   assign result    = result_q;
   assign depth     = depth_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q     <= '0;
         imm_q    <= '0;
         b_q      <= '0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         if (accept) begin
            op_q  <= cmd_op;
            imm_q <= cmd_imm;
            err_q <= !legal;
         end
         if (state == S_POP2) b_q <= stk_dout;
         if (state == S_CAP)  result_q <= stk_dout;
         if (state == S_WR)   result_q <= wr_value;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         depth_q <= '0;
      end else begin
         case ({stk_push, stk_pop})
            2'b10:   depth_q <= depth_q + ONE;
            2'b01:   depth_q <= depth_q - ONE;
            default: depth_q <= depth_q;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: includes a behavioural 32x8 stack and a queue-based
// command model that predicts strobes, latency, result, err and depth.

module tb_stack_op_sequencer;

   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_POP  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_NOT  = 3'b110;
   localparam logic [2:0] OP_DUP  = 3'b111;

   localparam logic [2:0] S_PU = 3'b100;
   localparam logic [2:0] S_PO = 3'b010;
   localparam logic [2:0] S_TO = 3'b001;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [7:0] cmd_imm = '0;
   logic       done, err;
   logic [7:0] result;
   logic [5:0] depth;
   logic       stk_push, stk_pop, stk_tos;
   logic [7:0] stk_din;
   logic [7:0] stk_dout;

   int checks = 0;
   int errors = 0;

   stack_op_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_imm(cmd_imm), .done(done), .err(err),
      .result(result), .depth(depth), .stk_push(stk_push), .stk_pop(stk_pop),
      .stk_tos(stk_tos), .stk_din(stk_din), .stk_dout(stk_dout)
   );

   always #5 clk = ~clk;

   // Hardware stack stand-in: registered Data_out, reset together with the sequencer.
   logic [7:0] smem [32];
   logic [5:0] sp;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp       <= '0;
         stk_dout <= '0;
      end else if (stk_push) begin
         smem[sp[4:0]] <= stk_din;
         sp            <= sp + 6'd1;
      end else if (stk_pop) begin
         stk_dout <= smem[5'(sp - 6'd1)];
         sp       <= sp - 6'd1;
      end else if (stk_tos) begin
         stk_dout <= smem[5'(sp - 6'd1)];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Command model state
   logic [7:0] mq[$];
   logic [7:0] m_res = '0;
   int         exp_lat;
   logic       exp_err;
   logic [7:0] exp_res;
   logic [7:0] exp_din;
   logic [2:0] exp_seq [4];
   bit         active = 0;
   bit         quiet  = 0;
   int         k = 0;

   task automatic model(input logic [2:0] op, input logic [7:0] imm);
      int d;
      bit ok;
      logic [7:0] a, b, r;
      d = mq.size();
      case (op)
         OP_PUSH:        ok = (d < 32);
         OP_POP, OP_NOT: ok = (d >= 1);
         OP_DUP:         ok = (d >= 1) && (d < 32);
         default:        ok = (d >= 2);
      endcase
      for (int i = 0; i < 4; i++) exp_seq[i] = 3'b000;
      exp_err = !ok;
      exp_din = '0;
      if (!ok) begin
         exp_lat = 1;
      end else begin
         case (op)
            OP_PUSH: begin
               mq.push_back(imm); m_res = imm; exp_din = imm;
               exp_seq[0] = S_PU; exp_lat = 2;
            end
            OP_POP: begin
               m_res = mq.pop_back();
               exp_seq[0] = S_PO; exp_lat = 3;
            end
            OP_NOT: begin
               a = mq.pop_back(); r = ~a;
               mq.push_back(r); m_res = r; exp_din = r;
               exp_seq[0] = S_PO; exp_seq[1] = S_PU; exp_lat = 3;
            end
            OP_DUP: begin
               a = mq[$];
               mq.push_back(a); m_res = a; exp_din = a;
               exp_seq[0] = S_TO; exp_seq[1] = S_PU; exp_lat = 3;
            end
            default: begin
               b = mq.pop_back();
               a = mq.pop_back();
               case (op)
                  OP_ADD:  r = a + b;
                  OP_SUB:  r = a - b;
                  OP_AND:  r = a & b;
                  default: r = a | b;
               endcase
               mq.push_back(r); m_res = r; exp_din = r;
               exp_seq[0] = S_PO; exp_seq[1] = S_PO; exp_seq[2] = S_PU; exp_lat = 4;
            end
         endcase
      end
      exp_res = m_res;
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (active) begin
         k++;
         if (k < exp_lat) begin
            chk("strobes", {stk_push, stk_pop, stk_tos}, exp_seq[k-1]);
            if (exp_seq[k-1] == S_PU) chk("din", stk_din, exp_din);
            chk("done_early", done, 1'b0);
            chk("ready_busy", cmd_ready, 1'b0);
         end else begin
            chk("done", done, 1'b1);
            chk("err", err, exp_err);
            chk("result", result, exp_res);
            chk("depth", depth, mq.size());
            chk("strobes_done", {stk_push, stk_pop, stk_tos}, 3'b000);
            active = 0;
         end
      end else if (rst && !quiet) begin
         chk("idle_done", done, 1'b0);
         chk("idle_strobes", {stk_push, stk_pop, stk_tos}, 3'b000);
         chk("idle_depth", depth, mq.size());
         chk("idle_ready", cmd_ready, 1'b1);
      end
   end

   task automatic do_cmd(input logic [2:0] op, input logic [7:0] imm, input bit hold);
      @(negedge clk); #1;
      chk("ready_before", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
      @(posedge clk); #1;
      model(op, imm);
      k = 0; active = 1;
      if (!hold) cmd_valid = 1'b0;
      else begin cmd_op = OP_POP; cmd_imm = 8'hAA; end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (!active) break;
      end
      if (active) begin
         errors++;
         $display("FAIL timeout: done never observed for op %0d", op);
         active = 0;
      end
      cmd_valid = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_depth", depth, 6'd0);
      chk("rst_result", result, 8'h00);
      chk("rst_done", {done, err}, 2'b00);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      do_cmd(OP_PUSH, 8'd5, 0);  chk("lit_push5", result, 8'd5);
      do_cmd(OP_PUSH, 8'd3, 0);  chk("lit_push3", result, 8'd3);
      chk("lit_depth2", depth, 6'd2);
      do_cmd(OP_SUB, 8'd0, 0);   chk("lit_sub2", result, 8'd2);
      chk("lit_depth1", depth, 6'd1);
      do_cmd(OP_POP, 8'd0, 0);
      do_cmd(OP_PUSH, 8'd3, 0);
      do_cmd(OP_PUSH, 8'd5, 0);
      do_cmd(OP_SUB, 8'd0, 0);   chk("lit_subFE", result, 8'hFE);
      do_cmd(OP_POP, 8'd0, 0);

      do_cmd(OP_PUSH, 8'h0F, 0);
      do_cmd(OP_DUP, 8'd0, 0);   chk("lit_dup", result, 8'h0F);
      chk("lit_dup_depth", depth, 6'd2);
      do_cmd(OP_AND, 8'd0, 0);   chk("lit_and", result, 8'h0F);
      do_cmd(OP_NOT, 8'd0, 0);   chk("lit_not", result, 8'hF0);
      do_cmd(OP_POP, 8'd0, 0);   chk("lit_pop", result, 8'hF0);
      chk("lit_depth0", depth, 6'd0);

      do_cmd(OP_POP, 8'd0, 0);   chk("lit_uflow_res", result, 8'hF0);
      do_cmd(OP_PUSH, 8'h01, 0);
      do_cmd(OP_ADD, 8'd0, 0);   chk("lit_add_rej_depth", depth, 6'd1);
      do_cmd(OP_PUSH, 8'hFF, 0);
      do_cmd(OP_ADD, 8'd0, 0);   chk("lit_add_wrap", result, 8'h00);
      do_cmd(OP_PUSH, 8'h0C, 0);
      do_cmd(OP_OR, 8'd0, 0);    chk("lit_or", result, 8'h0C);
      do_cmd(OP_POP, 8'd0, 0);

      for (int i = 0; i < 32; i++) do_cmd(OP_PUSH, 8'(i), 0);
      chk("lit_full", depth, 6'd32);
      do_cmd(OP_PUSH, 8'h77, 0);
      do_cmd(OP_DUP, 8'd0, 0);
      chk("lit_full_after_rej", depth, 6'd32);
      for (int i = 0; i < 32; i++) do_cmd(OP_POP, 8'd0, 0);
      chk("lit_last_pop", result, 8'd0);

      // Held cmd_valid with changing op/imm while busy: only the PUSH 0x5A runs
      do_cmd(OP_PUSH, 8'h5A, 1);
      chk("lit_hold_res", result, 8'h5A);
      chk("lit_hold_depth", depth, 6'd1);

      // Reset during POP2 of an ADD
      do_cmd(OP_PUSH, 8'd7, 0);
      @(negedge clk); #1;
      quiet = 1;
      cmd_valid = 1'b1; cmd_op = OP_ADD;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("abort_pop2", {stk_push, stk_pop, stk_tos}, S_PO);
      rst = 1'b0;
      #1;
      chk("abort_strobes", {stk_push, stk_pop, stk_tos}, 3'b000);
      chk("abort_depth", depth, 6'd0);
      chk("abort_done", done, 1'b0);
      mq.delete();
      m_res = '0;
      quiet = 0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("abort_ready", cmd_ready, 1'b1);
      do_cmd(OP_PUSH, 8'h42, 0);  chk("lit_after_rst", result, 8'h42);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
